proc_alu: RTL and testbench
===========================

Name: proc_alu

Overview:
- Single-cycle ALU for the embedded processor datapath.
- Selects operand A and operand B from register data, the switch bank or an immediate.
- Performs one of five operations: pass A, pass B, add, subtract, signed multiply-low.
- Registers the result and the V,N,Z,C flags on the clock edge, ready for writeback and branch logic.

Parameters:
- n, default 8: datapath width. Switch bus is n+1 bits; immediate is n bits.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- nReset, input, 1: one clock; reset is synchronous and active-low.
- a_in, input, n: register operand A.
- b_in, input, n: register operand B.
- func, input, 3: operation code (alu_pkg::alu_func_t).
- a_sel, input, 2: A-source select (alu_pkg::alu_sel_t).
- b_sel, input, 2: B-source select (alu_pkg::alu_sel_t).
- switches, input, n+1: board switches SW[n:0].
- immidiate, input, n: instruction immediate.
- result, output, n: registered result.
- flags, output, 4: registered flags {V,N,Z,C}, with V in bit 3 and C in bit 0.

Behaviour:
- Operand muxes (combinational):
  - REG=2'b00 selects a_in/b_in.
  - SW_7_0=2'b01 selects switches[n-1:0].
  - SW_8=2'b10 selects {n{switches[n]}}.
  - IMM=2'b11 selects immidiate for B only; for A, IMM selects a_in.
- func codes: RA=000, RB=001, RADD=010, RSUB=011, RMULL=100. Codes 101-111 are reserved and behave as RA.
- RA / RB: result = A / B. N = result[n-1], Z = (result==0), V = 0, C = 0.
- RADD: {cout,r} = A+B, computed n+1 bits wide.
  - C = cout.
  - V = (A[n-1]==B[n-1]) && (r[n-1]!=A[n-1]).
  - N = r[n-1], Z = (r==0).
- RSUB: r = A-B, modulo 2^n.
  - Vs = (A[n-1]!=B[n-1]) && (r[n-1]!=A[n-1]).
  - C = N ^ Vs, i.e. signed A < B.
  - V = (A[n-1]!=B[n-1]) && (r[n-1]==A[n-1]).
  - N = r[n-1], Z = (r==0).
- RMULL: r = low n bits of signed A × signed B (2n-bit product). N = r[n-1], Z = (r==0), V = 0, C = 0.
- Registers: on rising clk, if !nReset then result<=0 and flags<=4'b0000; else result and flags load the combinational values.
- Latency: exactly 1 cycle from input change to output. No handshake; a new operation is accepted every cycle.
- Reset asserted mid-stream: the next edge clears the outputs, and the in-flight operation is discarded.
- Reserved func codes and unused sel combinations never produce X.

Optional Feature:
- ALU_MUL_EN defined: RMULL is implemented as above.
- ALU_MUL_EN undefined: no multiplier is synthesised, and RMULL behaves as RA (result = A, flags per RA rules).

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_func_t {RA, RB, RADD, RSUB, RMULL}
  - typedef enum logic [1:0] alu_sel_t {REG, SW_7_0, SW_8, IMM}
  - flag bit index constants FLAG_V=3, FLAG_N=2, FLAG_Z=1, FLAG_C=0
- One sub-module, alu_operand_mux: it is instantiated twice, with a parameter disabling IMM for the A side.

Test Plan:
- Reset: hold nReset=0 for 2 cycles with RADD 1,1 applied -> result=0, flags=0000. Release -> next cycle result=2, flags=0000.
- RADD, REG/REG, n=8:
  - 0+0 -> 0, 0010
  - 255+1 -> 0, 0011
  - 5+(-10) -> -5, 0100
  - 127+127 -> -2 (0xFE), 1100
- RSUB:
  - 2-1 -> 1, 0000
  - -128-1 -> 127, 0001
  - -128-0 -> 128 (0x80), 1101
- Source select:
  - a_sel=SW_7_0, switches[7:0]=0x55, RA -> 0x55, 0000
  - a_sel=SW_8, switches[8]=0, RA -> 0x00, 0010; switches[8]=1 -> 0xFF, 0100
  - a_sel=IMM, imm=0x0F, a=-24, RA -> -24, 0100
  - b_sel=IMM, imm=0x0F, RB -> 0x0F, 0000
- b_sel=IMM, imm=-5, a=125, RADD -> 120, 0001.
- RMULL with ALU_MUL_EN defined:
  - 2×2 -> 4, 0000
  - 2×(-2) -> -4, 0100
  - 0x03×0x80 -> 0x80, 0100
- RMULL with ALU_MUL_EN undefined: a=7, b=3 -> 7, 0000.

Source files
------------

// File: rtl/proc_alu_pkg.sv
// Shared ALU types: operation codes, operand source selects and flag bit positions.
// Imported by the interface, the operand mux and the ALU top.
package alu_pkg;

  typedef enum logic [2:0] {
    RA    = 3'b000,
    RB    = 3'b001,
    RADD  = 3'b010,
    RSUB  = 3'b011,
    RMULL = 3'b100
  } alu_func_t;

  typedef enum logic [1:0] {
    REG    = 2'b00,
    SW_7_0 = 2'b01,
    SW_8   = 2'b10,
    IMM    = 2'b11
  } alu_sel_t;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/proc_alu_if.sv
// ALU operand/control bundle and registered result/flags.
// The master drives operands and control; the slave (ALU) returns result and flags.
interface proc_alu_if #(parameter int n = 8);
  import alu_pkg::*;

  logic [n-1:0] a_in;
  logic [n-1:0] b_in;
  alu_func_t    func;
  alu_sel_t     a_sel;
  alu_sel_t     b_sel;
  logic [n:0]   switches;
  logic [n-1:0] immidiate;
  logic [n-1:0] result;
  logic [3:0]   flags;

  modport master (
    output a_in, b_in, func, a_sel, b_sel, switches, immidiate,
    input  result, flags
  );

  modport slave (
    input  a_in, b_in, func, a_sel, b_sel, switches, immidiate,
    output result, flags
  );

endinterface

// File: rtl/proc_alu_operand_mux.sv
// Combinational operand source select (register, switch byte, replicated SW[n], immediate).
// Zero latency, no backpressure; IMM_EN=0 makes IMM fall back to the register operand.
module alu_operand_mux
  import alu_pkg::*;
#(
  parameter int n      = 8,
  parameter bit IMM_EN = 1'b1
) (
  input  alu_sel_t     sel,
  input  logic [n-1:0] reg_dat,
  input  logic [n:0]   switches,
  input  logic [n-1:0] imm_dat,
  output logic [n-1:0] op_dat
);

  always_comb begin
    op_dat = reg_dat;
    case (sel)
      REG:     op_dat = reg_dat;
      SW_7_0:  op_dat = switches[n-1:0];
      SW_8:    op_dat = {n{switches[n]}};
      IMM:     op_dat = IMM_EN ? imm_dat : reg_dat;
      default: op_dat = reg_dat;
    endcase
  end

endmodule

// File: rtl/proc_alu.sv
// Single-cycle ALU (RA/RB/ADD/SUB/MULL) with registered result and {V,N,Z,C} flags; ALU_MUL_EN enables RMULL.
// Latency 1 cycle; no backpressure, a new operation is accepted every cycle.
module proc_alu
  import alu_pkg::*;
#(
  parameter int n = 8
) (
  input  logic          clk,
  input  logic          nReset,
  proc_alu_if.slave     bus
);

  logic [n-1:0] a_op;
  logic [n-1:0] b_op;

  alu_operand_mux #(.n(n), .IMM_EN(1'b0)) u_a_mux (
    .sel      (bus.a_sel),
    .reg_dat  (bus.a_in),
    .switches (bus.switches),
    .imm_dat  (bus.immidiate),
    .op_dat   (a_op)
  );

  alu_operand_mux #(.n(n), .IMM_EN(1'b1)) u_b_mux (
    .sel      (bus.b_sel),
    .reg_dat  (bus.b_in),
    .switches (bus.switches),
    .imm_dat  (bus.immidiate),
    .op_dat   (b_op)
  );

  logic [n:0]   sum;
  logic [n-1:0] diff;
  logic         a_msb;
  logic         b_msb;

  assign sum   = {1'b0, a_op} + {1'b0, b_op};
  assign diff  = a_op - b_op;
  assign a_msb = a_op[n-1];
  assign b_msb = b_op[n-1];

`ifdef ALU_MUL_EN
  // Low n bits of the product are the same for signed and unsigned operands.
  logic signed [n-1:0] mul_lo;
  assign mul_lo = $signed(a_op) * $signed(b_op);
`endif

  logic [n-1:0] res_nxt;
  logic [3:0]   flg_nxt;
  logic         v_nxt;
  logic         c_nxt;

  always_comb begin
    res_nxt = a_op;
    v_nxt   = 1'b0;
    c_nxt   = 1'b0;
    case (bus.func)
      RB: res_nxt = b_op;
      RADD: begin
        res_nxt = sum[n-1:0];
        c_nxt   = sum[n];
        v_nxt   = (a_msb == b_msb) && (sum[n-1] != a_msb);
      end
      RSUB: begin
        res_nxt = diff;
        // C reports signed A < B: N xor true signed overflow.
        c_nxt   = diff[n-1] ^ ((a_msb != b_msb) && (diff[n-1] != a_msb));
        v_nxt   = (a_msb != b_msb) && (diff[n-1] == a_msb);
      end
`ifdef ALU_MUL_EN
      RMULL: res_nxt = mul_lo;
`endif
      default: res_nxt = a_op;
    endcase

    flg_nxt         = 4'b0000;
    flg_nxt[FLAG_V] = v_nxt;
    flg_nxt[FLAG_N] = res_nxt[n-1];
    flg_nxt[FLAG_Z] = (res_nxt == '0);
    flg_nxt[FLAG_C] = c_nxt;
  end

  logic [n-1:0] result_q;
  logic [3:0]   flags_q;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= res_nxt;
      flags_q  <= flg_nxt;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_proc_alu.sv
// Directed, table-driven bench for proc_alu (n=8) plus reset and latency sequences.
// RMULL expectations follow the ALU_MUL_EN build option.
module tb_proc_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic nReset = 1'b0;

  proc_alu_if #(.n(8)) bus ();

  proc_alu #(.n(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] func;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sw;
    logic [7:0] imm;
    logic [7:0] exp_res;
    logic [3:0] exp_flg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string name, logic [2:0] func, logic [1:0] a_sel, logic [1:0] b_sel,
                              logic [7:0] a, logic [7:0] b, logic [8:0] sw, logic [7:0] imm,
                              logic [7:0] exp_res, logic [3:0] exp_flg);
    vec_t v;
    v.name = name; v.func = func; v.a_sel = a_sel; v.b_sel = b_sel;
    v.a = a; v.b = b; v.sw = sw; v.imm = imm;
    v.exp_res = exp_res; v.exp_flg = exp_flg;
    return v;
  endfunction

  task automatic drive(logic [2:0] func, logic [1:0] a_sel, logic [1:0] b_sel,
                       logic [7:0] a, logic [7:0] b, logic [8:0] sw, logic [7:0] imm);
    bus.func      = alu_func_t'(func);
    bus.a_sel     = alu_sel_t'(a_sel);
    bus.b_sel     = alu_sel_t'(b_sel);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.switches  = sw;
    bus.immidiate = imm;
  endtask

  task automatic check(string name, logic [7:0] exp_res, logic [3:0] exp_flg);
    checks++;
    if (bus.result !== exp_res || bus.flags !== exp_flg) begin
      errors++;
      $display("FAIL %s: result=%h flags=%b, expected result=%h flags=%b",
               name, bus.result, bus.flags, exp_res, exp_flg);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Operand and expected values for an 8-bit datapath.
    vecs.push_back(mk("add_0_0",      3'b010, 2'b00, 2'b00, 8'h00, 8'h00, 9'h000, 8'h00, 8'h00, 4'b0010));
    vecs.push_back(mk("add_255_1",    3'b010, 2'b00, 2'b00, 8'hFF, 8'h01, 9'h000, 8'h00, 8'h00, 4'b0011));
    vecs.push_back(mk("add_5_m10",    3'b010, 2'b00, 2'b00, 8'h05, 8'hF6, 9'h000, 8'h00, 8'hFB, 4'b0100));
    vecs.push_back(mk("add_127_127",  3'b010, 2'b00, 2'b00, 8'h7F, 8'h7F, 9'h000, 8'h00, 8'hFE, 4'b1100));
    vecs.push_back(mk("sub_2_1",      3'b011, 2'b00, 2'b00, 8'h02, 8'h01, 9'h000, 8'h00, 8'h01, 4'b0000));
    vecs.push_back(mk("sub_m128_1",   3'b011, 2'b00, 2'b00, 8'h80, 8'h01, 9'h000, 8'h00, 8'h7F, 4'b0001));
    vecs.push_back(mk("sub_m128_0",   3'b011, 2'b00, 2'b00, 8'h80, 8'h00, 9'h000, 8'h00, 8'h80, 4'b1101));
    vecs.push_back(mk("ra_sw70",      3'b000, 2'b01, 2'b00, 8'h11, 8'h22, 9'h055, 8'h00, 8'h55, 4'b0000));
    vecs.push_back(mk("ra_sw8_0",     3'b000, 2'b10, 2'b00, 8'h11, 8'h22, 9'h0FF, 8'h00, 8'h00, 4'b0010));
    vecs.push_back(mk("ra_sw8_1",     3'b000, 2'b10, 2'b00, 8'h11, 8'h22, 9'h100, 8'h00, 8'hFF, 4'b0100));
    vecs.push_back(mk("ra_imm_is_a",  3'b000, 2'b11, 2'b00, 8'hE8, 8'h22, 9'h000, 8'h0F, 8'hE8, 4'b0100));
    vecs.push_back(mk("rb_imm",       3'b001, 2'b00, 2'b11, 8'hE8, 8'h22, 9'h000, 8'h0F, 8'h0F, 4'b0000));
    vecs.push_back(mk("add_125_immm5",3'b010, 2'b00, 2'b11, 8'h7D, 8'h00, 9'h000, 8'hFB, 8'h78, 4'b0001));
    vecs.push_back(mk("rb_sw70",      3'b001, 2'b00, 2'b01, 8'h00, 8'h00, 9'h1A5, 8'h00, 8'hA5, 4'b0100));
    vecs.push_back(mk("rsvd_101",     3'b101, 2'b00, 2'b00, 8'h33, 8'h44, 9'h000, 8'h00, 8'h33, 4'b0000));
    vecs.push_back(mk("rsvd_111",     3'b111, 2'b00, 2'b00, 8'h00, 8'h44, 9'h000, 8'h00, 8'h00, 4'b0010));
`ifdef ALU_MUL_EN
    vecs.push_back(mk("mul_2_2",      3'b100, 2'b00, 2'b00, 8'h02, 8'h02, 9'h000, 8'h00, 8'h04, 4'b0000));
    vecs.push_back(mk("mul_2_m2",     3'b100, 2'b00, 2'b00, 8'h02, 8'hFE, 9'h000, 8'h00, 8'hFC, 4'b0100));
    vecs.push_back(mk("mul_3_80",     3'b100, 2'b00, 2'b00, 8'h03, 8'h80, 9'h000, 8'h00, 8'h80, 4'b0100));
`else
    vecs.push_back(mk("mul_off_7_3",  3'b100, 2'b00, 2'b00, 8'h07, 8'h03, 9'h000, 8'h00, 8'h07, 4'b0000));
    vecs.push_back(mk("mul_off_2_m2", 3'b100, 2'b00, 2'b00, 8'h02, 8'hFE, 9'h000, 8'h00, 8'h02, 4'b0000));
    vecs.push_back(mk("mul_off_3_80", 3'b100, 2'b00, 2'b00, 8'h83, 8'h80, 9'h000, 8'h00, 8'h83, 4'b0100));
`endif

    // Reset held for two cycles with RADD 1+1 on the inputs.
    nReset = 1'b0;
    drive(3'b010, 2'b00, 2'b00, 8'h01, 8'h01, 9'h000, 8'h00);
    step();
    check("reset_cyc1", 8'h00, 4'b0000);
    step();
    check("reset_cyc2", 8'h00, 4'b0000);
    nReset = 1'b1;
    step();
    check("reset_release", 8'h02, 4'b0000);

    // Back-to-back table, one operation per cycle.
    foreach (vecs[i]) begin
      drive(vecs[i].func, vecs[i].a_sel, vecs[i].b_sel, vecs[i].a, vecs[i].b, vecs[i].sw, vecs[i].imm);
      step();
      check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_flg);
    end

    // Outputs must hold until the edge after an input change.
    drive(3'b010, 2'b00, 2'b00, 8'h10, 8'h20, 9'h000, 8'h00);
    step();
    check("lat_first", 8'h30, 4'b0000);
    drive(3'b011, 2'b00, 2'b00, 8'h05, 8'h05, 9'h000, 8'h00);
    #2;
    check("lat_hold", 8'h30, 4'b0000);
    step();
    check("lat_update", 8'h00, 4'b0010);

    // Mid-stream reset discards the in-flight operation.
    drive(3'b010, 2'b00, 2'b00, 8'h03, 8'h04, 9'h000, 8'h00);
    nReset = 1'b0;
    step();
    check("midreset_clear", 8'h00, 4'b0000);
    nReset = 1'b1;
    drive(3'b000, 2'b00, 2'b00, 8'h81, 8'h00, 9'h000, 8'h00);
    step();
    check("midreset_resume", 8'h81, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
